// File: rtl/pc_trace_fifo.sv
`default_nettype none
// ============================================================================
// Module   : pc_trace_fifo
// Brief    : Records PC discontinuities as {from,to} pairs in a valid/ready
//            drained FIFO and flags a halted core when the PC stops moving.
//            Optional PC_TRACE_OVF_CNT_EN adds an 8-bit dropped-entry counter.
// Revision : 1.0 - initial release
// ============================================================================
module pc_trace_fifo #(
    parameter int WIDTH       = 16,
    parameter int DEPTH       = 8,
    parameter int HALT_CYCLES = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           pc_new,
    input  logic                       trace_ready,
    output logic                       trace_valid,
    output logic [WIDTH-1:0]           trace_from,
    output logic [WIDTH-1:0]           trace_to,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       overflow,
    output logic                       halted
`ifdef PC_TRACE_OVF_CNT_EN
    ,
    output logic [7:0]                 ovf_count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int HW = $clog2(HALT_CYCLES + 1);

    logic [2*WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0]   r_pc_prev;
    logic               r_primed;
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [CW-1:0]      r_count;
    logic [HW-1:0]      r_halt_cnt;
    logic               r_overflow;

    logic               w_seq;
    logic               w_hold;
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_push_acc;
    logic               w_drop;
    logic [2*WIDTH-1:0] w_head;

    assign w_seq      = (pc_new == r_pc_prev + WIDTH'(1));
    assign w_hold     = (pc_new == r_pc_prev);
    assign w_push     = r_primed && !w_seq && !w_hold;
    assign w_pop      = trace_valid && trace_ready;
    assign w_full     = (r_count == CW'(DEPTH));
    // A pop on the same edge frees the slot a full FIFO needs for the push.
    assign w_push_acc = w_push && (!w_full || w_pop);
    assign w_drop     = w_push && w_full && !w_pop;
    assign w_head     = r_mem[r_rd_ptr];

    assign trace_valid = (r_count != '0);
    assign trace_from  = trace_valid ? w_head[2*WIDTH-1:WIDTH] : '0;
    assign trace_to    = trace_valid ? w_head[WIDTH-1:0]       : '0;
    assign fifo_count  = r_count;
    assign overflow    = r_overflow;
    assign halted      = (r_halt_cnt == HW'(HALT_CYCLES));

    // Storage is deliberately left out of reset; only pointers gate its use.
    always_ff @(posedge clk) begin
        if (!rst && w_push_acc) begin
            r_mem[r_wr_ptr] <= {r_pc_prev, pc_new};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc_prev  <= '0;
            r_primed   <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_halt_cnt <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_pc_prev <= pc_new;
            r_primed  <= 1'b1;

            if (r_primed) begin
                if (w_hold) begin
                    if (r_halt_cnt != HW'(HALT_CYCLES)) begin
                        r_halt_cnt <= r_halt_cnt + HW'(1);
                    end
                end else begin
                    r_halt_cnt <= '0;
                end
            end

            if (w_push_acc) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end

            case ({w_push_acc, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase

            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

`ifdef PC_TRACE_OVF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_count <= '0;
        end else if (w_drop && (ovf_count != 8'hFF)) begin
            ovf_count <= ovf_count + 8'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pc_trace_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_trace_fifo
// Brief    : Directed vector table plus multi-cycle sequences for pc_trace_fifo.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_trace_fifo;

    logic        clk;
    logic        rst;
    logic [15:0] pc_new;
    logic        trace_ready;
    logic        trace_valid;
    logic [15:0] trace_from;
    logic [15:0] trace_to;
    logic [3:0]  fifo_count;
    logic        overflow;
    logic        halted;
    logic [7:0]  ovf_count_obs;

    int vectors;
    int miscompares;

    pc_trace_fifo #(
        .WIDTH       (16),
        .DEPTH       (8),
        .HALT_CYCLES (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_new      (pc_new),
        .trace_ready (trace_ready),
        .trace_valid (trace_valid),
        .trace_from  (trace_from),
        .trace_to    (trace_to),
        .fifo_count  (fifo_count),
        .overflow    (overflow),
        .halted      (halted)
`ifdef PC_TRACE_OVF_CNT_EN
        ,
        .ovf_count   (ovf_count_obs)
`endif
    );

`ifndef PC_TRACE_OVF_CNT_EN
    assign ovf_count_obs = 8'd0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        ready;
        logic [15:0] pc;
        logic        valid;
        logic [15:0] from;
        logic [15:0] to;
        logic [3:0]  count;
        logic        ovf;
        logic        halt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic rdy, input logic [15:0] pc,
                                input logic v, input logic [15:0] f, input logic [15:0] t,
                                input logic [3:0] c, input logic o, input logic h);
        vec_t x;
        x.rst = r; x.ready = rdy; x.pc = pc; x.valid = v; x.from = f; x.to = t;
        x.count = c; x.ovf = o; x.halt = h;
        return x;
    endfunction

    task automatic apply(input logic r, input logic rdy, input logic [15:0] pc);
        @(negedge clk);
        rst         = r;
        trace_ready = rdy;
        pc_new      = pc;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic v, input logic [15:0] f,
                         input logic [15:0] t, input logic [3:0] c, input logic o,
                         input logic h, input logic [7:0] oc);
        logic bad;
        vectors++;
        bad = (trace_valid !== v) || (trace_from !== f) || (trace_to !== t) ||
              (fifo_count !== c) || (overflow !== o) || (halted !== h);
`ifdef PC_TRACE_OVF_CNT_EN
        bad = bad || (ovf_count_obs !== oc);
`endif
        if (bad) begin
            miscompares++;
            $display("FAIL %s: got v=%b from=%h to=%h cnt=%0d ovf=%b halt=%b oc=%0d; want v=%b from=%h to=%h cnt=%0d ovf=%b halt=%b oc=%0d",
                     name, trace_valid, trace_from, trace_to, fifo_count, overflow, halted,
                     ovf_count_obs, v, f, t, c, o, h, oc);
        end
    endtask

    function automatic logic [15:0] jf(input int k);
        return (k == 1) ? 16'h0005 : 16'(k - 1) << 12;
    endfunction

    function automatic logic [15:0] jt(input int k);
        return 16'(k) << 12;
    endfunction

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        trace_ready = 1'b0;
        pc_new      = '0;

        //           rst rdy pc        v  from      to        cnt ovf halt
        tbl.push_back(mk(1, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(0, 0, 16'hFFFD, 0, 16'h0000, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(0, 0, 16'hFFFE, 0, 16'h0000, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(0, 0, 16'hFFFF, 0, 16'h0000, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0001, 0, 16'h0000, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(1, 0, 16'h0001, 0, 16'h0000, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0010, 0, 16'h0000, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0011, 0, 16'h0000, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0040, 1, 16'h0011, 16'h0040, 1, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0041, 1, 16'h0011, 16'h0040, 1, 0, 0));
        tbl.push_back(mk(0, 1, 16'h0042, 0, 16'h0000, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(0, 1, 16'h0043, 0, 16'h0000, 16'h0000, 0, 0, 0));
        // Halt: arrival primes, fourth hold raises halted, sequential step drops it.
        tbl.push_back(mk(1, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0020, 0, 16'h0000, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0020, 0, 16'h0000, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0020, 0, 16'h0000, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0020, 0, 16'h0000, 16'h0000, 0, 0, 0));
        tbl.push_back(mk(0, 0, 16'h0020, 0, 16'h0000, 16'h0000, 0, 0, 1));
        tbl.push_back(mk(0, 0, 16'h0020, 0, 16'h0000, 16'h0000, 0, 0, 1));
        tbl.push_back(mk(0, 0, 16'h0021, 0, 16'h0000, 16'h0000, 0, 0, 0));

        foreach (tbl[i]) begin
            apply(tbl[i].rst, tbl[i].ready, tbl[i].pc);
            check($sformatf("vec%0d", i), tbl[i].valid, tbl[i].from, tbl[i].to,
                  tbl[i].count, tbl[i].ovf, tbl[i].halt, 8'd0);
        end

        // Overflow: 10 jumps into an 8-deep FIFO, then drain in push order.
        apply(1, 0, 16'h0000);
        apply(0, 0, 16'h0005);
        for (int k = 1; k <= 10; k++) begin
            apply(0, 0, jt(k));
            check($sformatf("ovf_fill%0d", k), 1'b1, 16'h0005, 16'h1000,
                  4'((k > 8) ? 8 : k), (k > 8), 1'b0, 8'((k > 8) ? k - 8 : 0));
        end
        for (int i = 1; i <= 8; i++) begin
            apply(0, 1, 16'hA000 + 16'(i));
            if (i < 8)
                check($sformatf("ovf_drain%0d", i), 1'b1, jf(i + 1), jt(i + 1),
                      4'(8 - i), 1'b1, 1'b0, 8'd2);
            else
                check("ovf_drain8", 1'b0, 16'h0000, 16'h0000, 4'd0, 1'b1, 1'b0, 8'd2);
        end

        // Full FIFO with push and pop on the same edge.
        apply(1, 0, 16'h0000);
        apply(0, 0, 16'h0005);
        for (int k = 1; k <= 8; k++) apply(0, 0, jt(k));
        check("full_fill", 1'b1, 16'h0005, 16'h1000, 4'd8, 1'b0, 1'b0, 8'd0);
        apply(0, 1, 16'h2345);
        check("full_pushpop", 1'b1, 16'h1000, 16'h2000, 4'd8, 1'b0, 1'b0, 8'd0);
        for (int i = 1; i <= 8; i++) begin
            apply(0, 1, 16'h2345 + 16'(i));
            if (i <= 6)
                check($sformatf("full_drain%0d", i), 1'b1, jf(i + 2), jt(i + 2),
                      4'(8 - i), 1'b0, 1'b0, 8'd0);
            else if (i == 7)
                check("full_drain7", 1'b1, 16'h8000, 16'h2345, 4'd1, 1'b0, 1'b0, 8'd0);
            else
                check("full_drain8", 1'b0, 16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0, 8'd0);
        end

        // One entry held, push and pop together: new entry becomes the head.
        apply(1, 0, 16'h0000);
        apply(0, 0, 16'h0100);
        apply(0, 0, 16'h0300);
        check("one_push", 1'b1, 16'h0100, 16'h0300, 4'd1, 1'b0, 1'b0, 8'd0);
        apply(0, 1, 16'h0500);
        check("one_pushpop", 1'b1, 16'h0300, 16'h0500, 4'd1, 1'b0, 1'b0, 8'd0);
        apply(0, 1, 16'h0501);
        check("one_drain", 1'b0, 16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0, 8'd0);

        // Reset mid-operation with 3 entries queued and overflow set.
        apply(1, 0, 16'h0000);
        apply(0, 0, 16'h0005);
        for (int k = 1; k <= 10; k++) apply(0, 0, jt(k));
        for (int i = 1; i <= 5; i++) apply(0, 1, 16'hA000 + 16'(i));
        check("mid_before", 1'b1, 16'h5000, 16'h6000, 4'd3, 1'b1, 1'b0, 8'd2);
        apply(1, 1, 16'h7777);
        check("mid_reset", 1'b0, 16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0, 8'd0);
        apply(0, 0, 16'h0300);
        check("mid_prime", 1'b0, 16'h0000, 16'h0000, 4'd0, 1'b0, 1'b0, 8'd0);
        apply(0, 0, 16'h0900);
        check("mid_jump", 1'b1, 16'h0300, 16'h0900, 4'd1, 1'b0, 1'b0, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
